add_seq_ctrl: RTL and testbench
===============================

ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width; SHALL be a multiple of SLICE.
REQ-002 Parameter SLICE, default 8: adder slice width processed per cycle; NSL = WIDTH/SLICE.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 in_valid  input  1  operand pair valid.
REQ-006 in_ready  output  1  controller can accept operands.
REQ-007 in_a, in_b  input  WIDTH  operands.
REQ-008 op_sub  input  1  1 = a - b, 0 = a + b.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 sum  output  WIDTH  result.
REQ-012 cout  output  1  carry out of MSB.
REQ-013 ovf  output  1  two's-complement signed overflow.
REQ-014 zero  output  1  sum == 0.
REQ-015 busy  output  1  state != IDLE.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DONE.
REQ-017 in_ready SHALL equal 1 only in IDLE; out_valid SHALL equal 1 only in DONE.
REQ-018 IDLE: in_valid=1 SHALL capture in_a, in_b (b inverted when subtracting), set the carry register to the subtract flag, clear slice counter k, and go to RUN.
REQ-019 RUN: each cycle SHALL add slice k of a and b with the carry register, write sum slice k, update the carry register, and increment k.
REQ-020 RUN SHALL go to DONE on the cycle processing slice NSL-1; cout = final carry; ovf = carry into MSB XOR carry out of MSB.
REQ-021 For a handshake in cycle n, out_valid SHALL first be 1 in cycle n+1+NSL (n+5 at defaults).
REQ-022 DONE: sum, cout, ovf, and zero SHALL hold stable while out_ready=0; out_ready=1 SHALL return the FSM to IDLE next cycle, with no same-cycle bypass to a new operation.
REQ-023 in_valid SHALL be ignored in RUN and DONE; operand inputs SHALL be sampled only at handshake.
REQ-024 k SHALL be log2(NSL) bits wide (minimum 1) and SHALL never wrap within an operation.
REQ-025 sum, cout, ovf, and zero SHALL keep their last values in IDLE until the next RUN overwrites them.

Reset
REQ-026 rst=1 SHALL force IDLE and clear k, the carry register, sum, cout, ovf, and out_valid; zero SHALL reset to 1 (consistent with sum = 0).
REQ-027 Reset mid-RUN or mid-DONE SHALL abort the operation with no result delivered; in_ready SHALL be 1 the cycle after rst deasserts.
REQ-028 rst SHALL take priority over any simultaneous handshake.

Configuration
REQ-029 Macro ADD_SEQ_SUB_EN defined: op_sub SHALL select subtraction per REQ-018.
REQ-030 ADD_SEQ_SUB_EN undefined: op_sub SHALL remain a port but be ignored; every operation SHALL be a + b with carry-in 0.

Structure
REQ-031 Package add_seq_pkg SHALL hold the state encoding constants (IDLE/RUN/DONE) and the default WIDTH/SLICE values.
REQ-032 One sub-module, add_slice: a combinational SLICE-bit carry-lookahead slice (a, b, cin -> s, cout, carry into its MSB), instantiated once and reused each RUN cycle.
REQ-033 All other logic (FSM, counter, operand/result registers, flags) SHALL reside in add_seq_ctrl.

Verification
REQ-034 0x0000_0001 + 0xFFFF_FFFF, handshake cycle n -> out_valid at n+5, sum=0x0000_0000, cout=1, zero=1, ovf=0.
REQ-035 0x7FFF_FFFF + 0x0000_0001 -> sum=0x8000_0000, ovf=1, cout=0, zero=0.
REQ-036 Result 0x1234_5678 + 0x1111_1111 with out_ready=0 for 3 cycles -> sum holds 0x2345_6789 and in_ready=0 throughout; out_ready=1 -> IDLE (in_ready=1) next cycle.
REQ-037 rst pulsed in the 2nd RUN cycle -> next cycle IDLE, out_valid=0, sum=0, zero=1; following 3 + 4 -> sum=7.
REQ-038 ADD_SEQ_SUB_EN defined: 5 - 7 -> sum=0xFFFF_FFFE, cout=0; undefined, same stimulus -> sum=0x0000_000C.
REQ-039 in_valid=1 with new operands throughout RUN -> ignored; the first result is unaffected and exactly one result is delivered.

Source files
------------

// File: rtl/add_seq_pkg.sv
// Shared state encoding and default sizing for the sequential slice adder.
package add_seq_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slice index width: log2 of the slice count, never narrower than one bit.
  function automatic int k_width(input int nsl);
    return (nsl <= 2) ? 1 : $clog2(nsl);
  endfunction

endpackage

// File: rtl/add_seq_ctrl_slice.sv
// add_slice: combinational SLICE-bit carry-lookahead adder slice; also exposes
// the carry into its MSB so the caller can derive signed overflow.
module add_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;
  logic [SLICE:0]   c;
  logic             ci;
  logic             prop;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is an independent sum of generate terms gated by the
  // propagate chain above them, so no carry depends on another.
  always_comb begin
    c    = '0;
    ci   = 1'b0;
    prop = 1'b1;
    for (int i = 0; i <= SLICE; i++) begin
      ci   = 1'b0;
      prop = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        ci   = ci | (g[j] & prop);
        prop = prop & p[j];
      end
      c[i] = ci | (cin & prop);
    end
  end

  assign s     = p ^ c[SLICE-1:0];
  assign cout  = c[SLICE];
  assign c_msb = c[SLICE-1];

endmodule

// File: rtl/add_seq_ctrl.sv
// Sequential WIDTH-bit adder/subtractor processing one SLICE per cycle.
// Define ADD_SEQ_SUB_EN to let op_sub select a - b; otherwise always a + b.
//
// state | meaning
// IDLE  | ready for an operand pair; previous result still visible
// RUN   | adding slice k each cycle, carry chained through carry_q
// DONE  | result valid, held until out_ready
module add_seq_ctrl
  import add_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             busy
);

  localparam int NSL = WIDTH / SLICE;
  localparam int KW  = k_width(NSL);

  state_t           state_q;
  state_t           state_d;
  logic [KW-1:0]    k_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_nxt;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             sub_eff;
  logic             last_slice;
  int               base;
  logic [SLICE-1:0] sl_s;
  logic             sl_cout;
  logic             sl_cmsb;

`ifdef ADD_SEQ_SUB_EN
  assign sub_eff = op_sub;
`else
  logic unused_op_sub;
  assign unused_op_sub = op_sub;
  assign sub_eff       = 1'b0;
`endif

  assign base       = 32'(k_q) * SLICE;
  assign last_slice = (k_q == KW'(NSL - 1));

  add_slice #(.SLICE(SLICE)) u_slice (
    .a     (a_q[base +: SLICE]),
    .b     (b_q[base +: SLICE]),
    .cin   (carry_q),
    .s     (sl_s),
    .cout  (sl_cout),
    .c_msb (sl_cmsb)
  );

  always_comb begin
    sum_nxt = sum_q;
    sum_nxt[base +: SLICE] = sl_s;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)   state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= in_a;
          b_q     <= sub_eff ? ~in_b : in_b;
          carry_q <= sub_eff;
          k_q     <= '0;
        end
        RUN: begin
          sum_q   <= sum_nxt;
          carry_q <= sl_cout;
          // Flags settle only on the final slice; k stops there instead of wrapping.
          if (last_slice) begin
            cout_q <= sl_cout;
            ovf_q  <= sl_cmsb ^ sl_cout;
            zero_q <= (sum_nxt == '0);
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed self-checking bench for add_seq_ctrl at default WIDTH=32, SLICE=8.
module tb_add_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        op_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  add_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair for exactly one edge; returns just after that edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
    in_a     = a;
    in_b     = b;
    op_sub   = sub;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Edges from now until out_valid, or -1 if it never comes.
  task automatic wait_done(output int cycles);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    cycles = out_valid ? n : -1;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_total++; if (sum !== 32'h0) $display("FAIL reset_sum got %h want 00000000", sum); else n_pass++;
    n_total++; if ({zero, cout, ovf} !== 3'b100) $display("FAIL reset_flags zco got %b want 100", {zero, cout, ovf}); else n_pass++;
  endtask

  task automatic test_carry_wrap();
    int cyc;
    start_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    n_total++; if ({in_ready, busy} !== 2'b01) $display("FAIL wrap_run_state rdy_busy got %b want 01", {in_ready, busy}); else n_pass++;
    wait_done(cyc);
    n_total++; if (cyc !== 4) $display("FAIL wrap_latency got %0d want 4", cyc); else n_pass++;
    n_total++; if (sum !== 32'h0) $display("FAIL wrap_sum got %h want 00000000", sum); else n_pass++;
    n_total++; if ({cout, zero, ovf} !== 3'b110) $display("FAIL wrap_flags czo got %b want 110", {cout, zero, ovf}); else n_pass++;
    accept();
  endtask

  task automatic test_overflow();
    int cyc;
    start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    wait_done(cyc);
    n_total++; if (cyc !== 4) $display("FAIL ovf_latency got %0d want 4", cyc); else n_pass++;
    n_total++; if (sum !== 32'h8000_0000) $display("FAIL ovf_sum got %h want 80000000", sum); else n_pass++;
    n_total++; if ({ovf, cout, zero} !== 3'b100) $display("FAIL ovf_flags ocz got %b want 100", {ovf, cout, zero}); else n_pass++;
    accept();
  endtask

  task automatic test_backpressure();
    int cyc;
    start_op(32'h1234_5678, 32'h1111_1111, 1'b0);
    wait_done(cyc);
    n_total++; if (cyc !== 4) $display("FAIL bp_latency got %0d want 4", cyc); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (sum !== 32'h2345_6789) $display("FAIL bp_hold_sum cycle %0d got %h want 23456789", i, sum); else n_pass++;
      n_total++; if ({in_ready, out_valid} !== 2'b01) $display("FAIL bp_hold_hs cycle %0d rdy_vld got %b want 01", i, {in_ready, out_valid}); else n_pass++;
      tick();
    end
    accept();
    n_total++; if ({in_ready, out_valid, busy} !== 3'b100) $display("FAIL bp_release rdy_vld_busy got %b want 100", {in_ready, out_valid, busy}); else n_pass++;
    n_total++; if (sum !== 32'h2345_6789 || zero !== 1'b0) $display("FAIL bp_idle_keep sum %h zero %b want 23456789 0", sum, zero); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    start_op(32'hAAAA_5555, 32'h0101_0101, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++; if ({in_ready, out_valid, busy} !== 3'b100) $display("FAIL midrst_state rdy_vld_busy got %b want 100", {in_ready, out_valid, busy}); else n_pass++;
    n_total++; if (sum !== 32'h0 || zero !== 1'b1) $display("FAIL midrst_result sum %h zero %b want 00000000 1", sum, zero); else n_pass++;
    start_op(32'd3, 32'd4, 1'b0);
    wait_done(cyc);
    n_total++; if (cyc !== 4) $display("FAIL midrst_next_latency got %0d want 4", cyc); else n_pass++;
    n_total++; if (sum !== 32'd7 || zero !== 1'b0) $display("FAIL midrst_next_sum sum %h zero %b want 00000007 0", sum, zero); else n_pass++;
    accept();
  endtask

  task automatic test_sub();
    int cyc;
    logic [31:0] exp_sum;
`ifdef ADD_SEQ_SUB_EN
    exp_sum = 32'hFFFF_FFFE;
`else
    exp_sum = 32'h0000_000C;
`endif
    start_op(32'd5, 32'd7, 1'b1);
    wait_done(cyc);
    n_total++; if (cyc !== 4) $display("FAIL sub_latency got %0d want 4", cyc); else n_pass++;
    n_total++; if (sum !== exp_sum) $display("FAIL sub_sum got %h want %h", sum, exp_sum); else n_pass++;
    n_total++; if ({cout, ovf} !== 2'b00) $display("FAIL sub_flags co got %b want 00", {cout, ovf}); else n_pass++;
    accept();
    start_op(32'd9, 32'd9, 1'b1);
    wait_done(cyc);
`ifdef ADD_SEQ_SUB_EN
    n_total++; if (sum !== 32'h0 || {cout, zero} !== 2'b11) $display("FAIL sub_equal sum %h cz %b want 00000000 11", sum, {cout, zero}); else n_pass++;
`else
    n_total++; if (sum !== 32'd18 || {cout, zero} !== 2'b00) $display("FAIL sub_equal sum %h cz %b want 00000012 00", sum, {cout, zero}); else n_pass++;
`endif
    accept();
  endtask

  task automatic test_ignore_in_valid();
    int results = 0;
    int n = 0;
    start_op(32'h0000_0010, 32'h0000_0020, 1'b0);
    in_a     = 32'hFFFF_FFFF;
    in_b     = 32'h0000_0001;
    in_valid = 1'b1;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    n_total++; if (n !== 4) $display("FAIL ign_latency got %0d want 4", n); else n_pass++;
    repeat (2) tick();
    n_total++; if (sum !== 32'h0000_0030 || zero !== 1'b0) $display("FAIL ign_sum sum %h zero %b want 00000030 0", sum, zero); else n_pass++;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) results++;
      tick();
    end
    out_ready = 1'b0;
    n_total++; if (results !== 1) $display("FAIL ign_result_count got %0d want 1", results); else n_pass++;
  endtask

  task automatic test_rst_priority();
    int seen = 0;
    in_a     = 32'd1;
    in_b     = 32'd2;
    in_valid = 1'b1;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    n_total++; if ({in_ready, busy} !== 2'b10) $display("FAIL rstprio_state rdy_busy got %b want 10", {in_ready, busy}); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      if (out_valid || busy) seen++;
      tick();
    end
    n_total++; if (seen !== 0) $display("FAIL rstprio_no_op active cycles got %0d want 0", seen); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_carry_wrap();
    test_overflow();
    test_backpressure();
    test_reset_mid_run();
    test_sub();
    test_ignore_in_valid();
    test_rst_priority();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
